alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle control unit for the 8-bit processor's combinational ALU. It fetches 16-bit instructions from a synchronous instruction ROM and decodes them. It drives the ALU operand and opcode lines, writes results into an internal 4×8 register file, and keeps carry/zero flags for conditional jumps. It sits between the instruction memory and the ALU and is the only master of the ALU inputs.

## Interface
- No parameters. Widths are fixed: 8-bit data, 8-bit PC, 16-bit instruction.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching at pc=0
- imem_addr  out  8  instruction address, registered
- imem_data  in  16  instruction word, valid one cycle after imem_addr changes
- alu_op1  out  8  ALU operand 1, registered
- alu_op2  out  8  ALU operand 2, registered
- alu_opcode  out  4  ALU opcode, registered
- alu_result  in  8  ALU result (combinational from alu_op*)
- alu_carry  in  1  ALU carry/borrow
- alu_zero  in  1  ALU zero
- busy  out  1  high in any state except IDLE and HALT
- halted  out  1  high in HALT
- wb_valid  out  1  one-cycle strobe on every register write
- wb_reg  out  2  register written
- wb_data  out  8  value written

## Operation
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- Opcodes:
  - 0000 ADD rd=rd+rs
  - 0001 SUB rd=rd−rs
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT rd=~rd
  - 0110 ADDI rd=rd+imm
  - 0111 JMP pc=imm
  - 1000 JZ pc=imm if Z
  - 1001 JC pc=imm if C
  - 1111 HALT
  - all others NOP (pc+1, no write, flags unchanged)
- ALU mapping: alu_op1=R[rd]. alu_op2 is R[rs], or imm for ADDI, or 0 for NOT. alu_opcode is the instruction opcode for 0000–0110 and 0000 otherwise.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
  - IDLE: waits for start, then goes to FETCH with pc=0. Register file is not cleared by start.
  - FETCH: imem_addr=pc. Always goes to DECODE.
  - DECODE: ir<=imem_data. Loads alu_op1/op2/opcode from the register file. Goes to EXECUTE.
  - EXECUTE, opcodes 0–6: latches alu_result into a result register and alu_carry/alu_zero into flags C/Z, then goes to WRITEBACK.
  - EXECUTE, jumps: pc<=imm if taken, else pc+1, then goes to FETCH. Flags unchanged.
  - EXECUTE, NOP: pc+1, then goes to FETCH. HALT opcode goes to HALT.
  - WRITEBACK: R[rd]<=result. wb_valid=1 with wb_reg=rd and wb_data=result. pc<=pc+1. Goes to FETCH.
  - HALT: terminal. start is ignored; only reset exits.
- Flags are updated only by opcodes 0–6. SUB carry means borrow (rd<rs). NOT forces C=0.
- PC arithmetic is modulo 256: 255+1 → 0, and fetching continues.
- start is ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE, pc=0, ir=0
  - R0–R3=0, C=0, Z=0
  - imem_addr=0, alu_op1=0, alu_op2=0, alu_opcode=0
  - busy=0, halted=0, wb_valid=0, wb_reg=0, wb_data=0
- reset has priority over all activity, including mid-instruction. The next state is IDLE and any pending register write is dropped.
- Cycle counts:
  - ALU ops: 4 cycles (F, D, E, W).
  - Jumps, NOP: 3 cycles.
  - HALT: 3 cycles to enter.
- First FETCH is the cycle after start is sampled.
- wb_valid is high for exactly the WRITEBACK cycle. The written value is readable by the next instruction's DECODE, so no hazards exist.
- alu_op*/alu_opcode are stable for the whole EXECUTE cycle. ALU outputs are sampled at the end of EXECUTE.
- A flag-setting instruction followed by JZ/JC uses the updated flags.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants (OP_ADD … OP_HALT)
  - the state enum
  - instruction field slice positions
- The ALU is instantiated outside this block and connected at the processor top level.
- One natural sub-module: `regfile4x8`, with 2 combinational read ports and 1 synchronous write port, reset to 0.

## Test plan
- ADDI R0,0x05; ADDI R1,0xFB; ADD R0,R1 → wb_data 0x05, 0xFB, 0x00. After the third op C=1, Z=1. Each ALU op takes 4 cycles.
- SUB R2,R3 with R2=0x03, R3=0x05 → wb_data 0xFE, C=1, Z=0. NOT R2 → 0x01, C=0.
- Flag-based jumps:
  - JZ 0x10 after a zero result → next imem_addr=0x10.
  - JZ 0x10 after a nonzero result → imem_addr=pc+1.
  - JC behaves the same way on the carry flag.
  - No wb_valid on any jump.
- JMP 0xFF, then a NOP at 0xFF → next imem_addr=0x00 (wrap). Undefined opcode 0xA → no write, flags unchanged.
- HALT → halted=1, busy=0 three cycles after its fetch. start pulse ignored. reset → halted=0, state IDLE.
- Assert reset during the EXECUTE of an ADD → no wb_valid, all outputs at reset values next cycle, R0–R3=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcodes, FSM states and
// the instruction word layout.
package cpu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned PC_W     = 8;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned REG_AW   = 2;
  localparam int unsigned NUM_REGS = 4;

  // Instruction field positions
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_MSB  = 9;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'h4;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'h5;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h8;
  localparam logic [OPC_W-1:0] OP_JC   = 4'h9;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Opcodes 0..6 go through the ALU and write back a result
  function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
    return opc <= OP_ADDI;
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
module regfile4x8
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller driving an external
// combinational ALU, with a private 4x8 register file and C/Z flags.
module alu_sequencer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [DATA_W-1:0]  alu_op1,
  output logic [DATA_W-1:0]  alu_op2,
  output logic [OPC_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  output logic               busy,
  output logic               halted,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_reg,
  output logic [DATA_W-1:0]  wb_data
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  instr_t            ir_q;
  instr_t            instr_c;
  logic [DATA_W-1:0] result_q;
  logic              c_q, z_q;

  logic              rf_we_c;
  logic [REG_AW-1:0] rf_raddr_a_c, rf_raddr_b_c;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
  logic [DATA_W-1:0] op2_c;
  logic [OPC_W-1:0]  opcode_c;

  assign instr_c = instr_t'(imem_data);

  // Ports address the incoming word in DECODE and track the latched one otherwise
  assign rf_raddr_a_c = (state_q == ST_DECODE) ? instr_c.rd : ir_q.rd;
  assign rf_raddr_b_c = (state_q == ST_DECODE) ? instr_c.rs : ir_q.rs;

  regfile4x8 u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we_c),
    .waddr   (ir_q.rd),
    .wdata   (result_q),
    .raddr_a (rf_raddr_a_c),
    .rdata_a (rf_rdata_a),
    .raddr_b (rf_raddr_b_c),
    .rdata_b (rf_rdata_b)
  );

  // Next-state, next-pc and register-file write enable
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rf_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + PC_W'(1);
        if (is_alu_op(ir_q.opcode)) begin
          state_d = ST_WRITEBACK;
          pc_d    = pc_q;
        end else begin
          case (ir_q.opcode)
            OP_JMP:  pc_d = ir_q.imm;
            OP_JZ:   if (z_q) pc_d = ir_q.imm;
            OP_JC:   if (c_q) pc_d = ir_q.imm;
            OP_HALT: begin
              state_d = ST_HALT;
              pc_d    = pc_q;
            end
            default: ;
          endcase
        end
      end
      ST_WRITEBACK: begin
        rf_we_c = 1'b1;
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand 2 and opcode selection for the instruction being decoded
  always_comb begin
    op2_c    = rf_rdata_b;
    opcode_c = OP_ADD;
    if (is_alu_op(instr_c.opcode)) opcode_c = instr_c.opcode;
    if (instr_c.opcode == OP_ADDI) op2_c = instr_c.imm;
    else if (instr_c.opcode == OP_NOT) op2_c = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      result_q   <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      imem_addr  <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opcode <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      wb_valid   <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_d == ST_FETCH) imem_addr <= pc_d;
      if (state_q == ST_DECODE) begin
        ir_q       <= instr_c;
        alu_op1    <= rf_rdata_a;
        alu_op2    <= op2_c;
        alu_opcode <= opcode_c;
      end
      if (state_q == ST_EXECUTE && is_alu_op(ir_q.opcode)) begin
        result_q <= alu_result;
        c_q      <= (ir_q.opcode == OP_NOT) ? 1'b0 : alu_carry;
        z_q      <= alu_zero;
      end
      wb_valid <= (state_d == ST_WRITEBACK);
      if (state_d == ST_WRITEBACK) begin
        wb_reg  <= ir_q.rd;
        wb_data <= alu_result;
      end
      busy   <= (state_d != ST_IDLE) && (state_d != ST_HALT);
      halted <= (state_d == ST_HALT);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ROM and ALU models around the DUT, checked against
// an instruction-level reference model of the processor.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  alu_op1, alu_op2;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_result;
  logic        alu_carry, alu_zero;
  logic        busy, halted, wb_valid;
  logic [1:0]  wb_reg;
  logic [7:0]  wb_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [256];

  // reference architectural state
  logic [7:0] m_r [4];
  logic       m_c, m_z;
  logic [7:0] m_pc;

  alu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .busy       (busy),
    .halted     (halted),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  // external combinational ALU
  always_comb begin
    logic [8:0] s;
    s = {1'b0, alu_op1} + {1'b0, alu_op2};
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    case (alu_opcode)
      4'h0, 4'h6: begin alu_result = s[7:0]; alu_carry = s[8]; end
      4'h1: begin alu_result = alu_op1 - alu_op2; alu_carry = alu_op1 < alu_op2; end
      4'h2: alu_result = alu_op1 & alu_op2;
      4'h3: alu_result = alu_op1 | alu_op2;
      4'h4: alu_result = alu_op1 ^ alu_op2;
      4'h5: alu_result = ~alu_op1;
      default: ;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_c  = 1'b0;
    m_z  = 1'b0;
    m_pc = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_alu_op1"}, alu_op1, 0);
    check({tag, "_alu_op2"}, alu_op2, 0);
    check({tag, "_alu_opcode"}, alu_opcode, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_wb_valid"}, wb_valid, 0);
    check({tag, "_wb_reg"}, wb_reg, 0);
    check({tag, "_wb_data"}, wb_data, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    model_reset();
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Executes up to n instructions, starting with the DUT in a FETCH cycle
  task automatic run_prog(input int n, input bit rand_start, output bit did_halt);
    logic [15:0] ins;
    logic [3:0]  op;
    logic [1:0]  rd, rs;
    logic [7:0]  imm, a, b, res;
    logic [8:0]  sum;
    logic        nc, alu;
    int          lat;
    did_halt = 1'b0;
    for (int i = 0; i < n; i++) begin
      ins = rom[m_pc];
      op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
      alu = (op <= 4'h6);
      a = m_r[rd];
      b = (op == 4'h6) ? imm : (op == 4'h5) ? 8'h00 : m_r[rs];
      sum = {1'b0, a} + {1'b0, b};
      res = 8'h00; nc = 1'b0;
      case (op)
        4'h0, 4'h6: begin res = sum[7:0]; nc = sum[8]; end
        4'h1: begin res = a - b; nc = (a < b); end
        4'h2: res = a & b;
        4'h3: res = a | b;
        4'h4: res = a ^ b;
        4'h5: res = ~a;
        default: ;
      endcase
      check("fetch_addr", imem_addr, m_pc);
      check("fetch_busy", busy, 1);
      lat = alu ? 4 : 3;
      for (int c = 0; c < lat; c++) begin
        check("wb_valid", wb_valid, (c == 3) ? 1 : 0);
        if (c == 2) begin
          check("exe_op1", alu_op1, a);
          check("exe_op2", alu_op2, b);
          check("exe_opcode", alu_opcode, alu ? op : 4'h0);
        end
        if (c == 3) begin
          check("wb_reg", wb_reg, rd);
          check("wb_data", wb_data, res);
        end
        if (rand_start) start = ($urandom_range(0, 4) == 0);
        tick();
      end
      start = 1'b0;
      if (alu) begin
        m_r[rd] = res; m_c = nc; m_z = (res == 8'h00); m_pc = m_pc + 8'd1;
      end else begin
        case (op)
          4'h7: m_pc = imm;
          4'h8: m_pc = m_z ? imm : m_pc + 8'd1;
          4'h9: m_pc = m_c ? imm : m_pc + 8'd1;
          4'hF: did_halt = 1'b1;
          default: m_pc = m_pc + 8'd1;
        endcase
      end
      if (did_halt) begin
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_wb_valid", wb_valid, 0);
        return;
      end
    end
  endtask

  initial begin
    bit h;
    logic [3:0] op;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000;
    tick();
    do_reset();
    tick();
    check("idle_no_start_busy", busy, 0);
    check("idle_no_start_addr", imem_addr, 0);

    // arithmetic, flags, taken/untaken jumps and pc wrap
    rom[8'h00] = 16'h6005;  rom[8'h01] = 16'h64FB;  rom[8'h02] = 16'h0100;
    rom[8'h03] = 16'h8010;  rom[8'h10] = 16'h9020;  rom[8'h20] = 16'h6803;
    rom[8'h21] = 16'h6C05;  rom[8'h22] = 16'h1B00;  rom[8'h23] = 16'h8040;
    rom[8'h24] = 16'h5800;  rom[8'h25] = 16'h9040;  rom[8'h26] = 16'h70FF;
    rom[8'hFF] = 16'hA000;
    start_run();
    run_prog(14, 1'b1, h);
    check("wrap_r0_again", m_pc, 8'h01);

    // HALT entry, start ignored while halted, reset leaves HALT
    do_reset();
    rom[8'h00] = 16'hF000;
    start_run();
    run_prog(2, 1'b0, h);
    check("halt_reached", h, 1);
    start_run();
    tick();
    check("halt_ignores_start", halted, 1);
    check("halt_addr_hold", imem_addr, 0);
    do_reset();
    check("post_halt_halted", halted, 0);

    // reset during EXECUTE of an ADD drops the write
    rom[8'h00] = 16'h6005;  rom[8'h01] = 16'h0000;
    start_run();
    run_prog(1, 1'b0, h);
    check("mid_fetch_addr", imem_addr, 1);
    tick();
    tick();
    check("mid_exe_op1", alu_op1, 8'h05);
    reset = 1'b1;
    tick();
    check_reset_outputs("mid");
    reset = 1'b0;
    model_reset();
    rom[8'h00] = 16'h6000;  rom[8'h01] = 16'h6400;  rom[8'h02] = 16'h6800;
    rom[8'h03] = 16'h6C00;  rom[8'h04] = 16'hF000;
    start_run();
    run_prog(6, 1'b0, h);
    check("regs_cleared_halt", h, 1);

    // random programs
    for (int p = 0; p < 8; p++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 6));
        rom[a] = {op, 12'($urandom)};
      end
      start_run();
      run_prog(50, 1'b1, h);
    end
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
